// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load extraction/extension and sub-word store merge.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] ld_val,
    output logic [31:0] st_val
);

    logic [4:0]  sh;
    logic [31:0] sw;
    logic [31:0] mask;
    logic [31:0] data;

    assign sh   = {offset, 3'b000};
    assign sw   = word >> sh;
    assign data = wdata << sh;

    always_comb begin
        ld_val = '0;
        case (funct3)
            F3_B:    ld_val = {{24{sw[7]}}, sw[7:0]};
            F3_H:    ld_val = {{16{sw[15]}}, sw[15:0]};
            F3_W:    ld_val = sw;
            F3_BU:   ld_val = {24'd0, sw[7:0]};
            F3_HU:   ld_val = {16'd0, sw[15:0]};
            default: ld_val = '0;
        endcase
    end

    always_comb begin
        mask = '1;
        case (funct3)
            F3_B:    mask = 32'h0000_00ff << sh;
            F3_H:    mask = 32'h0000_ffff << sh;
            default: mask = '1;
        endcase
    end

    assign st_val = (word & ~mask) | (data & mask);

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit driving a word-addressed data memory port.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);

    state_t      state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] wd_q;
    logic [31:0] ld_val;
    logic [31:0] st_val;
    logic        accept;
    logic        misal;
    logic        illegal;
    logic        range_bad;
    logic        bad;

    assign req_ready  = (state == IDLE) || ((state == RESP) && resp_ready);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign mem_WE     = (state == ACCESS) && we_q;
    // Merged word is live only during the write cycle; otherwise hold the last one.
    assign mem_WD     = mem_WE ? st_val : wd_q;

    always_comb begin
        misal = 1'b0;
        case (req_funct3)
            F3_H, F3_HU: misal = req_addr[0];
            F3_W:        misal = (req_addr[1:0] != 2'b00);
            default:     misal = 1'b0;
        endcase
    end

    always_comb begin
        illegal = 1'b0;
        if (req_we)
            illegal = (req_funct3 != F3_B) && (req_funct3 != F3_H) && (req_funct3 != F3_W);
        else
            illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    end

    assign range_bad = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
    assign bad       = misal || illegal || range_bad;

    lsu_lane_align u_align (
        .word   (mem_RD),
        .offset (off_q),
        .funct3 (f3_q),
        .wdata  (wdata_q),
        .ld_val (ld_val),
        .st_val (st_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            f3_q       <= '0;
            off_q      <= '0;
            wdata_q    <= '0;
            wd_q       <= '0;
            mem_A      <= '0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata;
            if (bad) begin
                state      <= RESP;
                resp_err   <= 1'b1;
                resp_rdata <= '0;
            end else begin
                state <= ACCESS;
                mem_A <= {req_addr[31:2], 2'b00};
            end
        end else begin
            case (state)
                ACCESS: begin
                    state      <= RESP;
                    resp_err   <= 1'b0;
                    resp_rdata <= we_q ? 32'd0 : ld_val;
                    if (we_q)
                        wd_q <= st_val;
                end
                RESP: begin
                    if (resp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: byte-level reference model, per-cycle compare.
module tb_lsu_mem_master;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        req_valid = 0;
    logic        req_ready;
    logic        req_we = 0;
    logic [2:0]  req_funct3 = 0;
    logic [31:0] req_addr = 0;
    logic [31:0] req_wdata = 0;
    logic        resp_valid;
    logic        resp_ready = 1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [31:0] mem_RD;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    bit rnd_on = 0;

    bit          cur_lit_en = 0;
    logic [31:0] cur_lit_rd = 0;
    logic        cur_lit_err = 0;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
        bit          lit_en;
        logic [31:0] lit_rd;
        logic        lit_err;
    } ent_t;

    ent_t q[$];
    int          exp_we_cyc = -1;
    logic [31:0] exp_wa = 0;
    logic [31:0] exp_wd = 0;

    lsu_mem_master #(.MEM_WORDS(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_A      (mem_A),
        .mem_WD     (mem_WD),
        .mem_WE     (mem_WE),
        .mem_RD     (mem_RD)
    );

    always #5 clk = ~clk;

    assign mem_RD = mem[mem_A[7:2]];
    always @(posedge clk) if (mem_WE) mem[mem_A[7:2]] <= mem_WD;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rbyte(int a);
        return 8'(ref_mem[(a >> 2) % 64] >> (8 * (a % 4)));
    endfunction

    // Spec-level model: error rules, byte-by-byte load assembly, byte-by-byte store.
    function automatic void model(input bit we, input bit [2:0] f3, input bit [31:0] a,
                                  input bit [31:0] wd, output bit err,
                                  output logic [31:0] rd, output logic [31:0] word);
        int n;
        longint v;
        bit mis, ill, oor;
        n   = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
        mis = (n == 2 && a % 2 != 0) || (n == 4 && a % 4 != 0);
        ill = we ? (f3 > 2) : (f3 == 3 || f3 >= 6);
        oor = (a / 4) >= 64;
        err = mis || ill || oor;
        rd = 0;
        word = 0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < n; i++) begin
                int b;
                b = int'(a % 4) + i;
                ref_mem[a / 4][8*b +: 8] = 8'(wd >> (8 * i));
            end
            word = ref_mem[a / 4];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++)
                v = v + (longint'(rbyte(int'(a) + i)) << (8 * i));
            if (f3[2] == 0 && n < 4 && v >= (longint'(1) << (8 * n - 1)))
                v = v - (longint'(1) << (8 * n));
            rd = 32'(v);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_we_cyc = -1;
        end else begin
            bit          busy_resp;
            bit          exp_ready;
            bit          e;
            logic [31:0] r;
            logic [31:0] w;
            ent_t        en;
            if (cyc == exp_we_cyc) begin
                chk("mem_WE", 32'(mem_WE), 1);
                chk("mem_A", mem_A, exp_wa);
                chk("mem_WD", mem_WD, exp_wd);
            end else begin
                chk("mem_WE idle", 32'(mem_WE), 0);
            end
            busy_resp = (q.size() > 0) && (cyc >= q[0].due);
            if (busy_resp) begin
                chk("resp_valid", 32'(resp_valid), 1);
                chk("resp_rdata", resp_rdata, q[0].rdata);
                chk("resp_err", 32'(resp_err), 32'(q[0].err));
            end else begin
                chk("resp_valid low", 32'(resp_valid), 0);
            end
            exp_ready = (q.size() == 0) || (busy_resp && resp_ready);
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            if (busy_resp && resp_ready) begin
                if (q[0].lit_en) begin
                    chk("lit rdata", resp_rdata, q[0].lit_rd);
                    chk("lit err", 32'(resp_err), 32'(q[0].lit_err));
                end
                void'(q.pop_front());
            end
            if (req_valid && exp_ready) begin
                model(req_we, req_funct3, req_addr, req_wdata, e, r, w);
                en.due     = cyc + 1 + (e ? 0 : 1);
                en.rdata   = r;
                en.err     = e;
                en.lit_en  = cur_lit_en;
                en.lit_rd  = cur_lit_rd;
                en.lit_err = cur_lit_err;
                q.push_back(en);
                if (req_we && !e) begin
                    exp_we_cyc = cyc + 1;
                    exp_wa     = {req_addr[31:2], 2'b00};
                    exp_wd     = w;
                end
            end
        end
    end

    always @(posedge clk) if (rnd_on) #1 resp_ready = ($urandom % 4) != 0;

    task automatic setreq(bit we, bit [2:0] f3, bit [31:0] a, bit [31:0] wd,
                          bit le, logic [31:0] lrd, logic lerr);
        req_we      = we;
        req_funct3  = f3;
        req_addr    = a;
        req_wdata   = wd;
        cur_lit_en  = le;
        cur_lit_rd  = lrd;
        cur_lit_err = lerr;
        req_valid   = 1;
    endtask

    // Returns one step after the accept edge, i.e. inside the ACCESS/RESP cycle.
    task automatic issue(bit we, bit [2:0] f3, bit [31:0] a, bit [31:0] wd,
                         bit le, logic [31:0] lrd, logic lerr);
        int n;
        setreq(we, f3, a, wd, le, lrd, lerr);
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("accept timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid  = 0;
        cur_lit_en = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 0;
            ref_mem[i] = 0;
        end
        mem[0] = 32'hFACEFACE;
        ref_mem[0] = 32'hFACEFACE;
        mem[1] = 32'h00000002;
        ref_mem[1] = 32'h00000002;

        #12;
        chk("rst req_ready", 32'(req_ready), 1);
        chk("rst resp_valid", 32'(resp_valid), 0);
        chk("rst resp_err", 32'(resp_err), 0);
        chk("rst resp_rdata", resp_rdata, 0);
        chk("rst mem_WE", 32'(mem_WE), 0);
        chk("rst mem_A", mem_A, 0);
        chk("rst mem_WD", mem_WD, 0);
        @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        #1;

        issue(0, 3'b010, 32'h0, 0, 1, 32'hFACEFACE, 0);
        repeat (3) @(posedge clk);
        #1;

        issue(0, 3'b000, 32'h1, 0, 1, 32'hFFFFFFFA, 0);
        issue(0, 3'b100, 32'h2, 0, 1, 32'h000000CE, 0);
        issue(0, 3'b001, 32'h2, 0, 1, 32'hFFFFFACE, 0);
        issue(0, 3'b101, 32'h0, 0, 1, 32'h0000FACE, 0);

        issue(1, 3'b000, 32'h5, 32'h123456AB, 1, 0, 0);
        chk("SB mem_WE", 32'(mem_WE), 1);
        chk("SB mem_A", mem_A, 32'h4);
        chk("SB mem_WD", mem_WD, 32'h0000AB02);
        issue(0, 3'b010, 32'h4, 0, 1, 32'h0000AB02, 0);

        issue(1, 3'b001, 32'h3, 32'hFFFF, 1, 0, 1);
        issue(0, 3'b010, 32'h100, 0, 1, 0, 1);
        issue(1, 3'b100, 32'h4, 32'hFFFFFFFF, 1, 0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("mem0 after errs", mem[0], 32'hFACEFACE);
        chk("mem1 after errs", mem[1], 32'h0000AB02);

        resp_ready = 0;
        issue(0, 3'b010, 32'h4, 0, 1, 32'h0000AB02, 0);
        setreq(0, 3'b010, 32'h0, 0, 1, 32'hFACEFACE, 0);
        repeat (4) @(posedge clk);
        #1 resp_ready = 1;
        issue(0, 3'b010, 32'h0, 0, 1, 32'hFACEFACE, 0);
        repeat (3) @(posedge clk);
        #1;

        issue(1, 3'b010, 32'h0, 32'h0, 0, 0, 0);
        rst_n = 0;
        #1;
        chk("rst mid mem_WE", 32'(mem_WE), 0);
        chk("rst mid resp_valid", 32'(resp_valid), 0);
        chk("rst mid req_ready", 32'(req_ready), 1);
        ref_mem[0] = 32'hFACEFACE;
        @(posedge clk);
        #1 rst_n = 1;
        chk("rst mid word0", mem[0], 32'hFACEFACE);
        @(posedge clk);
        #1;

        rnd_on = 1;
        for (int k = 0; k < 400; k++) begin
            bit [31:0] a;
            a = ($urandom % 8 == 0) ? $urandom : $urandom_range(0, 255);
            issue(1'($urandom), 3'($urandom), a, $urandom, 0, 0, 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rnd_on = 0;
        #2 resp_ready = 1;
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) chk($sformatf("final mem[%0d]", i), mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
